multdiv_sequencer: RTL and testbench

Multi-cycle sequencer for the CPU's shared multiply/divide unit. Detects `mult`/`div` (R-type, opcode 00000, ALU op 00110/00111) in decode/execute, stalls the pipeline, launches the unit with a one-cycle control pulse, and waits for the result or a timeout. It then hands the result, or an `rstatus` exception write to `$r30`, to the pipeline for one cycle. Sits beside the execute stage, between the main decode controller and the multdiv unit.

---
 rtl/cpu_defs.sv | 16 +
 rtl/md_timeout_counter.sv | 24 ++
 rtl/multdiv_sequencer.sv | 86 ++++++++
 tb/tb_multdiv_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU decode constants and multdiv sequencer state encoding
package cpu_defs;
    localparam logic [4:0]  OP_RTYPE     = 5'b00000;
    localparam logic [4:0]  ALU_MULT     = 5'b00110;
    localparam logic [4:0]  ALU_DIV      = 5'b00111;
    localparam logic [4:0]  REG_RSTATUS  = 5'd30;
    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_BUSY = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;

    function automatic logic is_md_op(input logic valid, input logic [4:0] opcode, input logic [4:0] aluop);
        return valid && opcode == OP_RTYPE && (aluop == ALU_MULT || aluop == ALU_DIV);
    endfunction
endpackage

// File: rtl/md_timeout_counter.sv
// md_timeout_counter: saturating busy-cycle counter that flags when TIMEOUT cycles have elapsed
module md_timeout_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    assign expired = count == LIMIT;

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: stalls the pipeline around a multi-cycle mult/div and hands back its result
module multdiv_sequencer
    import cpu_defs::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_valid,
    input  logic [4:0]  dx_opcode,
    input  logic [4:0]  dx_aluop,
    input  logic [4:0]  dx_rd,
    input  logic        flush,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        op_latch,
    output logic        stall,
    output logic        res_valid,
    output logic [4:0]  res_rd,
    output logic [31:0] res_data,
    output logic        res_exception
);
    logic [1:0]  state;
    logic [4:0]  lat_rd;
    logic        lat_div;
    logic [31:0] cap_data;
    logic        cap_exc;
    logic        accept;
    logic        first;
    logic        expired;

    assign accept        = state == S_IDLE && is_md_op(dx_valid, dx_opcode, dx_aluop) && !flush;
    // the start pulse marks the first BUSY cycle, where a stale md_ready must be ignored
    assign first         = ctrl_mult | ctrl_div;
    assign op_latch      = accept;
    assign stall         = accept | (state == S_BUSY);
    assign res_valid     = state == S_DONE;
    assign res_exception = res_valid & cap_exc;
    assign res_rd        = !res_valid ? '0 : cap_exc ? REG_RSTATUS : lat_rd;
    assign res_data      = !res_valid ? '0 : cap_exc ? (lat_div ? RSTATUS_DIV : RSTATUS_MULT) : cap_data;

    md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (state == S_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            lat_rd    <= '0;
            lat_div   <= 1'b0;
            cap_data  <= '0;
            cap_exc   <= 1'b0;
        end else begin
            ctrl_mult <= accept & ~dx_aluop[0];
            ctrl_div  <= accept & dx_aluop[0];
            if (accept) begin
                state   <= S_BUSY;
                lat_rd  <= dx_rd;
                lat_div <= dx_aluop[0];
            end else if (state == S_BUSY) begin
                if (flush) begin
                    state <= S_IDLE;
                end else if (md_ready && !first) begin
                    state    <= S_DONE;
                    cap_data <= md_result;
                    cap_exc  <= md_exception;
                end else if (expired) begin
                    state    <= S_DONE;
                    cap_data <= '0;
                    cap_exc  <= 1'b1;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed and random stimulus checked against a cycles-since-detect reference model
module tb_multdiv_sequencer;
    localparam int TO = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_valid;
    logic [4:0]  dx_opcode;
    logic [4:0]  dx_aluop;
    logic [4:0]  dx_rd;
    logic        flush;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        op_latch;
    logic        stall;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        res_exception;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: an op is in flight t cycles after its detect cycle; pend means its result shows this cycle
    bit          inflight = 0;
    bit          pend = 0;
    int          t = 0;
    logic [4:0]  m_rd = '0;
    bit          m_div = 0;
    logic [31:0] m_data = '0;
    bit          m_exc = 0;

    multdiv_sequencer #(.TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .dx_valid      (dx_valid),
        .dx_opcode     (dx_opcode),
        .dx_aluop      (dx_aluop),
        .dx_rd         (dx_rd),
        .flush         (flush),
        .md_ready      (md_ready),
        .md_exception  (md_exception),
        .md_result     (md_result),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .op_latch      (op_latch),
        .stall         (stall),
        .res_valid     (res_valid),
        .res_rd        (res_rd),
        .res_data      (res_data),
        .res_exception (res_exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                        input bit fl, input bit rdy, input bit ex, input logic [31:0] res, input bit rs);
        bit is_md, acc;
        reset = rs; dx_valid = v; dx_opcode = op; dx_aluop = alu; dx_rd = rd;
        flush = fl; md_ready = rdy; md_exception = ex; md_result = res;
        is_md = v && op == 5'd0 && (alu == 5'd6 || alu == 5'd7);
        acc = !inflight && !pend && is_md && !fl;
        #3;
        chk("op_latch", 32'(op_latch), 32'(acc));
        chk("stall", 32'(stall), 32'(acc || inflight));
        chk("ctrl_mult", 32'(ctrl_mult), 32'(inflight && t == 1 && !m_div));
        chk("ctrl_div", 32'(ctrl_div), 32'(inflight && t == 1 && m_div));
        chk("res_valid", 32'(res_valid), 32'(pend));
        chk("res_exception", 32'(res_exception), 32'(pend && m_exc));
        chk("res_rd", 32'(res_rd), !pend ? 32'd0 : m_exc ? 32'd30 : 32'(m_rd));
        chk("res_data", res_data, !pend ? 32'd0 : m_exc ? (m_div ? 32'd5 : 32'd4) : m_data);
        @(posedge clock);
        #1;
        cyc++;
        if (rs) begin
            inflight = 0; pend = 0;
        end else if (pend) begin
            pend = 0;
        end else if (inflight) begin
            if (fl) inflight = 0;
            else if (rdy && t >= 2) begin inflight = 0; pend = 1; m_data = res; m_exc = ex; end
            else if (t == TO + 1) begin inflight = 0; pend = 1; m_exc = 1; end
            else t++;
        end else if (acc) begin
            inflight = 1; t = 1; m_rd = rd; m_div = alu[0];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'hdead_beef, 0);
    endtask

    task automatic md(input bit div, input logic [4:0] rd);
        step(1, 5'd0, div ? 5'd7 : 5'd6, rd, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic ready(input bit ex, input logic [31:0] res);
        step(0, 0, 0, 0, 0, 1, ex, res, 0);
    endtask

    initial begin
        reset = 1; dx_valid = 0; dx_opcode = 0; dx_aluop = 0; dx_rd = 0;
        flush = 0; md_ready = 0; md_exception = 0; md_result = 0;
        repeat (2) @(posedge clock);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // mult 7x6 into r5, result ready 20 cycles after detect
        md(0, 5'd5); idle(19); ready(0, 32'd42); idle(2);
        // div with divide-by-zero
        md(1, 5'd9); idle(3); ready(1, 32'h1234); idle(2);
        // timeout on a mult
        md(0, 5'd3); idle(TO + 4);
        // timeout on a div
        md(1, 5'd3); idle(TO + 4);
        // flush in BUSY, then a late md_ready
        md(0, 5'd7); idle(4); step(1, 0, 6, 8, 1, 0, 0, 0, 0); ready(0, 32'd99); idle(3);
        // md_ready in the pulse cycle is ignored
        md(0, 5'd11); ready(0, 32'd1); idle(2); ready(0, 32'd77); idle(2);
        // reset mid-BUSY then a fresh mult
        md(0, 5'd12); idle(2); step(0, 0, 0, 0, 0, 1, 0, 5, 1); idle(2);
        md(0, 5'd13); idle(2); ready(0, 32'h55aa); idle(2);
        // rd=0 still presents res_valid
        md(1, 5'd0); idle(1); ready(0, 32'hcafe); idle(2);
        // flush in IDLE with an md op, and non-md R-type op
        step(1, 0, 6, 4, 1, 0, 0, 0, 0); step(1, 0, 5, 4, 0, 0, 0, 0, 0); step(1, 1, 6, 4, 0, 0, 0, 0, 0); idle(1);
        // back-to-back: md op held in DX across DONE
        md(0, 5'd14); idle(1); ready(0, 32'd3); md(1, 5'd15); md(1, 5'd15); md(1, 5'd15); ready(0, 32'd8); idle(2);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0 ? 5'($urandom) : 5'd0,
                 $urandom_range(0, 5) == 0 ? 5'($urandom) : 5'($urandom_range(6, 7)), 5'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                 $urandom, $urandom_range(0, 99) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
